fp_align_sequencer: RTL and testbench

Multi-cycle exponent-alignment controller for the single-precision adder path. It accepts two IEEE-754 binary32 operands over a valid/ready handshake and compares their 8-bit exponents with the 9-bit two's-complement subtract. It then sequences a serial right-shifter over the mantissa of the smaller-exponent operand and presents both 24-bit mantissas (hidden bit restored) aligned to a common exponent for the downstream mantissa adder.

---
 rtl/fp_align_sequencer.sv | 164 ++++++++++++++++
 tb/tb_fp_align_sequencer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/fp_align_sequencer.sv
// rtl/fp_align_sequencer.sv - binary32 exponent compare and serial mantissa alignment controller
// Optional sticky accumulation is built when ALIGN_STICKY_EN is defined.
module fp_align_sequencer #(
    parameter int STEP = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  exp_out,
    output logic [23:0] man_keep,
    output logic [23:0] man_shift,
    output logic        sign_keep,
    output logic        sign_shift,
    output logic        swapped,
    output logic        too_big,
    output logic        sticky
);

    typedef enum logic [1:0] {IDLE, CMP, SHIFT, DONE} state_t;

    localparam logic [4:0] STEP_W = 5'(STEP);

    state_t      state_q, state_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [7:0]  exp_q, exp_d;
    logic [23:0] keep_q, keep_d, shift_q, shift_d;
    logic        sgn_keep_q, sgn_keep_d, sgn_shift_q, sgn_shift_d;
    logic        swapped_q, swapped_d, too_big_q, too_big_d;
    logic [4:0]  cnt_q, cnt_d;

    logic [8:0]  diff;
    logic        swap;
    logic [7:0]  mag;
    logic [23:0] man_a, man_b, pre_shift_man, drop_mask;
    logic [4:0]  amt;

    // Hidden bit follows the raw exponent field; zero exponents are not renormalised.
    assign man_a         = {|a_q[30:23], a_q[22:0]};
    assign man_b         = {|b_q[30:23], b_q[22:0]};
    assign diff          = {1'b0, a_q[30:23]} - {1'b0, b_q[30:23]};
    assign swap          = diff[8];
    assign mag           = swap ? (~diff[7:0] + 8'd1) : diff[7:0];
    assign pre_shift_man = swap ? man_a : man_b;
    assign amt           = (cnt_q < STEP_W) ? cnt_q : STEP_W;
    assign drop_mask     = (24'd1 << amt) - 24'd1;

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        exp_d       = exp_q;
        keep_d      = keep_q;
        shift_d     = shift_q;
        sgn_keep_d  = sgn_keep_q;
        sgn_shift_d = sgn_shift_q;
        swapped_d   = swapped_q;
        too_big_d   = too_big_q;
        cnt_d       = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    state_d = CMP;
                end
            end
            CMP: begin
                swapped_d   = swap;
                exp_d       = swap ? b_q[30:23] : a_q[30:23];
                keep_d      = swap ? man_b : man_a;
                shift_d     = pre_shift_man;
                sgn_keep_d  = swap ? b_q[31] : a_q[31];
                sgn_shift_d = swap ? a_q[31] : b_q[31];
                too_big_d   = (mag >= 8'd25);
                cnt_d       = mag[4:0];
                if (mag >= 8'd25) begin
                    shift_d = '0;
                    state_d = DONE;
                end else if (mag == 8'd0) begin
                    state_d = DONE;
                end else begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                shift_d = shift_q >> amt;
                cnt_d   = cnt_q - amt;
                if (cnt_q == amt) state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            exp_q       <= '0;
            keep_q      <= '0;
            shift_q     <= '0;
            sgn_keep_q  <= 1'b0;
            sgn_shift_q <= 1'b0;
            swapped_q   <= 1'b0;
            too_big_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            exp_q       <= exp_d;
            keep_q      <= keep_d;
            shift_q     <= shift_d;
            sgn_keep_q  <= sgn_keep_d;
            sgn_shift_q <= sgn_shift_d;
            swapped_q   <= swapped_d;
            too_big_q   <= too_big_d;
            cnt_q       <= cnt_d;
        end
    end

`ifdef ALIGN_STICKY_EN
    logic sticky_q, sticky_d;

    // Collects every bit that falls off the low end of the shifted mantissa.
    always_comb begin
        sticky_d = sticky_q;
        case (state_q)
            IDLE:    if (in_valid) sticky_d = 1'b0;
            CMP:     if (mag >= 8'd25) sticky_d = |pre_shift_man;
            SHIFT:   sticky_d = sticky_q | (|(shift_q & drop_mask));
            default: sticky_d = sticky_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sticky_q <= 1'b0;
        else        sticky_q <= sticky_d;
    end

    assign sticky = sticky_q;
`else
    assign sticky = 1'b0;
`endif

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign exp_out    = exp_q;
    assign man_keep   = keep_q;
    assign man_shift  = shift_q;
    assign sign_keep  = sgn_keep_q;
    assign sign_shift = sgn_shift_q;
    assign swapped    = swapped_q;
    assign too_big    = too_big_q;

endmodule

// File: tb/tb_fp_align_sequencer.sv
// tb/tb_fp_align_sequencer.sv - directed self-checking bench for fp_align_sequencer (STEP=1)
module tb_fp_align_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  exp_out;
    logic [23:0] man_keep, man_shift;
    logic        sign_keep, sign_shift, swapped, too_big, sticky;

    int checks = 0;
    int errors = 0;

`ifdef ALIGN_STICKY_EN
    localparam logic STK = 1'b1;
`else
    localparam logic STK = 1'b0;
`endif

    fp_align_sequencer #(.STEP(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .exp_out(exp_out), .man_keep(man_keep), .man_shift(man_shift),
        .sign_keep(sign_keep), .sign_shift(sign_shift), .swapped(swapped),
        .too_big(too_big), .sticky(sticky)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Presents one operand pair, returns the measured latency (acceptance cycle counts as 1).
    task automatic issue(input logic [31:0] av, input logic [31:0] bv, output int lat);
        @(negedge clk);
        chk("in_ready_before_issue", in_ready, 1);
        a = av;
        b = bv;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        a = 32'hDEADBEEF;
        b = 32'h12345678;
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic expect_result(input string tag, input int lat, input int e_lat,
                                 input logic [7:0] e_exp, input logic [23:0] e_keep,
                                 input logic [23:0] e_shift, input logic e_sk, input logic e_ss,
                                 input logic e_sw, input logic e_tb, input logic e_st);
        chk({tag, "_latency"}, lat, e_lat);
        chk({tag, "_out_valid"}, out_valid, 1);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_exp_out"}, exp_out, e_exp);
        chk({tag, "_man_keep"}, man_keep, e_keep);
        chk({tag, "_man_shift"}, man_shift, e_shift);
        chk({tag, "_sign_keep"}, sign_keep, e_sk);
        chk({tag, "_sign_shift"}, sign_shift, e_ss);
        chk({tag, "_swapped"}, swapped, e_sw);
        chk({tag, "_too_big"}, too_big, e_tb);
        chk({tag, "_sticky"}, sticky, e_st);
    endtask

    task automatic complete(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_in_ready_after"}, in_ready, 1);
        chk({tag, "_out_valid_after"}, out_valid, 0);
    endtask

    int lat;
    logic [23:0] held_shift;

    initial begin
        #2;
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_exp_out", exp_out, 0);
        chk("reset_man_keep", man_keep, 0);
        chk("reset_man_shift", man_shift, 0);
        chk("reset_flags", {sign_keep, sign_shift, swapped, too_big, sticky}, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // 3.0 vs 1.0, d=1
        issue(32'h40400000, 32'h3F800000, lat);
        expect_result("d1", lat, 3, 8'h80, 24'hC00000, 24'h400000, 0, 0, 0, 0, 0);
        complete("d1");

        // 1.0 vs 10.0, d=3 swapped
        issue(32'h3F800000, 32'h41200000, lat);
        expect_result("swap", lat, 5, 8'h82, 24'hA00000, 24'h100000, 0, 0, 1, 0, 0);
        complete("swap");

        // equal exponents
        issue(32'h3F800000, 32'h3FC00000, lat);
        expect_result("eq", lat, 2, 8'h7F, 24'h800000, 24'hC00000, 0, 0, 0, 0, 0);
        complete("eq");

        // d=24 boundary: everything shifted out, not too_big
        issue(32'h4B800000, 32'h3F800001, lat);
        expect_result("d24", lat, 26, 8'h97, 24'h800000, 24'h000000, 0, 0, 0, 0, STK);
        complete("d24");

        // d=25 boundary: too_big path
        issue(32'h4C000000, 32'h3F800001, lat);
        expect_result("d25", lat, 2, 8'h98, 24'h800000, 24'h000000, 0, 0, 0, 1, STK);
        complete("d25");

        // signs: -3.0 vs 1.0; sticky must have cleared on acceptance
        issue(32'hC0400000, 32'h3F800000, lat);
        expect_result("neg", lat, 3, 8'h80, 24'hC00000, 24'h400000, 1, 0, 0, 0, 0);
        complete("neg");

        // zero-exponent operand: no hidden bit, swapped, a low bit dropped
        issue(32'h80000005, 32'h00800000, lat);
        expect_result("subn", lat, 3, 8'h01, 24'h800000, 24'h000002, 0, 1, 1, 0, STK);
        complete("subn");

        // backpressure with ignored in_valid pulses
        issue(32'h40400000, 32'h3F800000, lat);
        expect_result("bp", lat, 3, 8'h80, 24'hC00000, 24'h400000, 0, 0, 0, 0, 0);
        held_shift = man_shift;
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0);
            a = 32'h7F000000;
            b = 32'h00800000;
            @(posedge clk);
            #1 in_valid = 1'b0;
            @(negedge clk);
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_in_ready", in_ready, 0);
            chk("bp_hold_shift", man_shift, held_shift);
            chk("bp_hold_exp", exp_out, 8'h80);
        end
        complete("bp");
        repeat (3) begin
            @(negedge clk);
            chk("bp_no_spurious", out_valid, 0);
        end

        // reset in the middle of a d=20 shift
        issue(32'h49800000, 32'h3F800000, lat);
        chk("mid_reset_setup", lat, 22);
        complete("mid_reset_setup");
        @(negedge clk);
        a = 32'h49800000;
        b = 32'h3F800000;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_in_ready", in_ready, 1);
        chk("arst_out_valid", out_valid, 0);
        chk("arst_exp_out", exp_out, 0);
        chk("arst_man_keep", man_keep, 0);
        chk("arst_man_shift", man_shift, 0);
        chk("arst_flags", {sign_keep, sign_shift, swapped, too_big, sticky}, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (25) begin
            @(negedge clk);
            chk("arst_discarded", out_valid, 0);
        end
        issue(32'h40400000, 32'h3F800000, lat);
        expect_result("post_rst", lat, 3, 8'h80, 24'hC00000, 24'h400000, 0, 0, 0, 0, 0);
        complete("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
